// File: rtl/reg_file_pkg.sv
// Shared register-file constants and the index-encoder state type.
// Contents:
//   N       - number of registers (mask width)
//   W       - register index width, $clog2(N)
//   state_e - index encoder control state {IDLE, SCAN}
package reg_file_pkg;

  localparam int N = 32;
  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/prio_enc_32_to_5.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   vec  in  N  multi-hot input vector
//   idx  out W  position of the lowest set bit of vec (0 when vec is 0)
//   any  out 1  vec has at least one bit set
module prio_enc_32_to_5
  import reg_file_pkg::*;
(
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/reg_index_encoder.sv
// Sequential 32-to-5 index encoder for the register-file write-back path.
// Takes a multi-hot register mask and streams out the index of each set
// bit, lowest first, one per idx handshake.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous abort of the pending batch
//   req_valid/req_ready    mask handshake, req_mask is the register mask
//   idx_valid/idx_ready    index handshake
//   idx, idx_last          current index and final-bit-of-batch flag
//   zero_drop              one-cycle pulse after an all-zero mask is accepted
//   pending                bits not yet issued (observability)
module reg_index_encoder
  import reg_file_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_mask,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [W-1:0] idx,
  output logic         idx_last,
  output logic         zero_drop,
  output logic [N-1:0] pending
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_drop_q, zero_drop_d;

  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic [N-1:0] idx_onehot;
  logic         single_bit;
  logic         idx_hs;
  logic         req_hs;

  prio_enc_32_to_5 u_prio_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Outputs depend only on registered state and pending, so they hold
  // steady under backpressure.
  assign single_bit = ((pending_q & (pending_q - N'(1))) == '0);
  assign idx_valid  = (state_q == SCAN) && enc_any;
  assign idx        = idx_valid ? enc_idx : '0;
  assign idx_last   = idx_valid && single_bit;
  assign idx_onehot = N'(1) << enc_idx;

  assign idx_hs    = idx_valid && idx_ready;
  // A new mask is taken in IDLE, or in SCAN only on the final handshake so
  // the next batch follows without a bubble.
  assign req_ready = !flush && ((state_q == IDLE) || (idx_hs && idx_last));
  assign req_hs    = req_valid && req_ready;

  assign zero_drop = zero_drop_q;
  assign pending   = pending_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;

    if (idx_hs) begin
      pending_d = pending_q & ~idx_onehot;
      if (idx_last) state_d = IDLE;
    end

    if (req_hs) begin
      if (req_mask != '0) begin
        pending_d = req_mask;
        state_d   = SCAN;
      end else begin
        zero_drop_d = 1'b1;
        state_d     = IDLE;
      end
    end

    // Flush wins; a handshake in this cycle has already been consumed above.
    if (flush) begin
      pending_d = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule

// File: doc/reg_index_encoder.md
# reg_index_encoder

Sequential 32-to-5 index encoder for the register-file write-back path, the inverse of the 5-to-32 select decoder. It accepts a multi-hot 32-bit register mask and emits the 5-bit index of each set bit, one per handshake, lowest index first. The index stream drives the register-file select port, so a batch of register updates (e.g. a load-multiple or dirty-set write-back) is serialised onto a single write port.

## Interface
- N, 32, mask width (number of registers)
- W, 5, index width, equal to $clog2(N)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; discards the pending batch
- req_valid  in  1  mask offered
- req_ready  out  1  block can accept a mask this cycle
- req_mask  in  N  multi-hot register mask
- idx_valid  out  1  idx holds a valid register index
- idx_ready  in  1  consumer takes idx this cycle
- idx  out  W  current register index; 0 when idx_valid=0
- idx_last  out  1  idx is the final set bit of the batch; 0 when idx_valid=0
- zero_drop  out  1  one-cycle pulse: an all-zero mask was accepted and discarded
- pending  out  N  bits not yet issued; debug/observability

## Operation
- Two states, IDLE and SCAN, held in registered `state` alongside registered `pending[N-1:0]`.
- IDLE: req_ready=1, idx_valid=0.
  - On req_valid with nonzero req_mask: pending <= req_mask, go to SCAN.
  - On req_valid with req_mask=0: accept the mask, pulse zero_drop next cycle, stay in IDLE.
- SCAN: idx_valid=1; idx = position of the lowest set bit of pending; idx_last = (pending & (pending-1)) == 0.
  - On idx_ready with idx_last=0: clear bit idx in pending, stay in SCAN.
  - On idx_ready with idx_last=1: clear the bit and go to IDLE, unless a new mask is accepted in the same cycle.
- Back-to-back batches: in SCAN, req_ready = idx_valid & idx_ready & idx_last. A nonzero mask accepted in that cycle loads pending directly and the block stays in SCAN with no bubble. A zero mask accepted in that cycle goes to IDLE and pulses zero_drop.
- req_ready is 0 in SCAN at all other times. A held req_valid waits.
- flush has priority over every other event:
  - pending <= 0, state <= IDLE.
  - No mask is accepted in the flush cycle; req_ready is forced to 0.
  - An idx handshake in the flush cycle still completes; it is the last index issued.
- idx and idx_last must not change while idx_valid=1 and idx_ready=0.
- Widths: idx is exactly W bits. The bit clear uses an N-bit one-hot of idx.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, pending=0, idx_valid=0, idx=0, idx_last=0, zero_drop=0, req_ready=1.
- Mask accepted at edge k: the first idx is valid in the cycle after k, i.e. 1-cycle latency.
- Throughput is one index per cycle while idx_ready=1. A batch of p set bits drains in p cycles.
- Output timing:
  - idx, idx_valid and idx_last are combinational from registered state and pending only; there is no input-to-output path.
  - req_ready depends combinationally on idx_ready.
- Reset asserted mid-batch clears everything immediately. No partial index is emitted after release.

## Structure
- Shared package `reg_file_pkg`: N, W constants and the state enum {IDLE, SCAN}. The decoder uses the same N and W.
- One sub-module: `prio_enc_32_to_5`. It is a combinational lowest-set-bit encoder with outputs idx[W-1:0] and any. The top-level FSM, pending register and handshake logic instantiate it once.

## Test plan
- Basic batch:
  - Stimulus: req_mask=32'h0000_2009 with idx_ready held 1.
  - Required response: idx = 0, 3, 13 on consecutive cycles; idx_last=1 only with 13; IDLE on the cycle after.
- Backpressure:
  - Stimulus: req_mask=32'h8000_0001 with idx_ready low for 3 cycles.
  - Required response: idx=0 stable with idx_valid=1 throughout the stall; then 0, then 31 with idx_last=1.
- Back-to-back:
  - Stimulus: mask 32'h0000_0010 then 32'h0000_0006, req_valid held.
  - Required response: second mask accepted on the idx_last handshake of idx=4; indices 4, 1, 2 on three consecutive cycles with no bubble.
- Zero mask:
  - Stimulus: req_mask=0 in IDLE.
  - Required response: accepted; zero_drop pulses for one cycle; idx_valid stays 0.
- Flush:
  - Stimulus: req_mask=32'hFFFF_FFFF; flush asserted after 5 indices.
  - Required response: pending=0, idx_valid=0 on the next cycle; req_ready=0 during the flush cycle.
- Async reset:
  - Stimulus: rst_n pulsed low mid-batch, between clock edges.
  - Required response: all outputs at reset values immediately; the first index after release comes only from a newly accepted mask.
